// File: rtl/rtc_bus_sequencer.sv
// Bus-cycle sequencer for the multiplexed address/data RTC interface.
// Runs single or burst read/write transactions with parameterised strobe phase timing.
module rtc_bus_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 4,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_RECOVER = 3,
  parameter int unsigned BURST_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               op,
  input  logic [DATA_W-1:0]  addr,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0]  wdata,
  output logic               wdata_ack,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  rdata,
  output logic               rdata_valid,
  output logic               cs_n,
  output logic               rd_n,
  output logic               wr_n,
  output logic               a_d,
  output logic [DATA_W-1:0]  dout,
  input  logic [DATA_W-1:0]  din,
  output logic               bus_oe
);

  localparam int unsigned TMaxSp = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned TMaxHr = (T_HOLD > T_RECOVER) ? T_HOLD : T_RECOVER;
  localparam int unsigned TMax   = (TMaxSp > TMaxHr) ? TMaxSp : TMaxHr;
  localparam int unsigned CntW   = $clog2(TMax + 1);

  localparam logic [CntW-1:0] SetupLast   = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] PulseLast   = CntW'(T_PULSE - 1);
  localparam logic [CntW-1:0] HoldLast    = CntW'(T_HOLD - 1);
  localparam logic [CntW-1:0] RecoverLast = CntW'(T_RECOVER - 1);

  typedef enum logic [3:0] {
    StIdle, StASetup, StAPulse, StAHold, StDSetup, StDPulse, StDHold, StRecover, StDone
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic [DATA_W-1:0]    addr_q, addr_d;
  logic [BURST_W-1:0]   words_q, words_d;
  logic                 abort_q, abort_d;
  logic                 phase_last;

  logic                 cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic                 a_d_q, a_d_d, bus_oe_q, bus_oe_d;
  logic [DATA_W-1:0]    dout_q, dout_d, rdata_q, rdata_d;
  logic                 rdata_valid_q, rdata_valid_d, wdata_ack_q, wdata_ack_d;
  logic                 busy_q, busy_d, done_q, done_d;

  always_comb begin
    phase_last = 1'b1;
    unique case (state_q)
      StASetup, StDSetup: phase_last = (cnt_q == SetupLast);
      StAPulse, StDPulse: phase_last = (cnt_q == PulseLast);
      StAHold,  StDHold:  phase_last = (cnt_q == HoldLast);
      StRecover:          phase_last = (cnt_q == RecoverLast);
      default:            phase_last = 1'b1;
    endcase
  end

  // Sequencing: phase counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    op_d    = op_q;
    addr_d  = addr_q;
    words_d = words_q;
    abort_d = abort_q | (busy_q & abort);
    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (start) begin
          state_d = StASetup;
          op_d    = op;
          addr_d  = addr;
          words_d = (burst_len == '0) ? BURST_W'(1) : burst_len;
        end
      end
      StASetup: if (phase_last) state_d = StAPulse;
      StAPulse: if (phase_last) state_d = StAHold;
      StAHold:  if (phase_last) state_d = StDSetup;
      StDSetup: if (phase_last) state_d = StDPulse;
      StDPulse: if (phase_last) state_d = StDHold;
      StDHold: begin
        if (phase_last) begin
          state_d = StRecover;
          words_d = words_q - BURST_W'(1);
          addr_d  = addr_q + DATA_W'(1);
        end
      end
      StRecover: begin
        if (phase_last) state_d = ((words_q != '0) && !abort_d) ? StASetup : StDone;
      end
      StDone: begin
        state_d = StIdle;
        abort_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Pin and status outputs are decoded from the next state so they leave a flop.
  always_comb begin
    cs_n_d        = 1'b1;
    rd_n_d        = 1'b1;
    wr_n_d        = 1'b1;
    bus_oe_d      = 1'b0;
    a_d_d         = a_d_q;
    dout_d        = dout_q;
    wdata_ack_d   = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    busy_d        = (state_d != StIdle) && (state_d != StDone);
    done_d        = (state_d == StDone);
    unique case (state_d)
      StASetup, StAPulse, StAHold: begin
        cs_n_d   = 1'b0;
        bus_oe_d = 1'b1;
        wr_n_d   = (state_d != StAPulse);
      end
      StDSetup, StDPulse, StDHold: begin
        cs_n_d   = 1'b0;
        bus_oe_d = ~op_d;
        wr_n_d   = !((state_d == StDPulse) && !op_d);
        rd_n_d   = !((state_d == StDPulse) && op_d);
      end
      default: ;
    endcase
    if ((state_d == StASetup) && (state_q != StASetup)) begin
      a_d_d  = 1'b0;
      dout_d = addr_d;
    end
    if ((state_d == StDSetup) && (state_q != StDSetup)) begin
      a_d_d = 1'b1;
      if (!op_d) begin
        dout_d      = wdata;
        wdata_ack_d = 1'b1;
      end
    end
    if ((state_q == StDPulse) && phase_last && op_q) begin
      rdata_d       = din;
      rdata_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      op_q          <= 1'b0;
      addr_q        <= '0;
      words_q       <= '0;
      abort_q       <= 1'b0;
      cs_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      a_d_q         <= 1'b0;
      bus_oe_q      <= 1'b0;
      dout_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      wdata_ack_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      words_q       <= words_d;
      abort_q       <= abort_d;
      cs_n_q        <= cs_n_d;
      rd_n_q        <= rd_n_d;
      wr_n_q        <= wr_n_d;
      a_d_q         <= a_d_d;
      bus_oe_q      <= bus_oe_d;
      dout_q        <= dout_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      wdata_ack_q   <= wdata_ack_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign cs_n        = cs_n_q;
  assign rd_n        = rd_n_q;
  assign wr_n        = wr_n_q;
  assign a_d         = a_d_q;
  assign bus_oe      = bus_oe_q;
  assign dout        = dout_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign wdata_ack   = wdata_ack_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Parametrised bus-cycle sequencer for the multiplexed address/data real-time-clock interface. It replaces the fixed-timing control path with one engine that runs single or burst read/write transactions. Every strobe phase duration is set by a parameter. The block sits between the RTC register-access controller (start/op/addr/wdata handshake) and the chip pins (cs_n, rd_n, wr_n, a_d, dout/din, bus_oe).

## Interface
Parameters:
- DATA_W, 8: width of the address/data bus and of the internal address.
- T_SETUP, 2: cycles in each SETUP phase (≥1).
- T_PULSE, 4: cycles the RD/WR strobe is held low (≥1).
- T_HOLD, 2: cycles in each HOLD phase (≥1).
- T_RECOVER, 3: idle cycles between words (≥1).
- BURST_W, 4: width of burst_len.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = write, 1 = read; captured with start.
- addr  in  DATA_W  first RTC register address; captured with start.
- burst_len  in  BURST_W  number of words; 0 is treated as 1.
- wdata  in  DATA_W  write data for the current word.
- wdata_ack  out  1  one-cycle pulse when wdata is sampled.
- abort  in  1  finish the current word, then terminate.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  last word read.
- rdata_valid  out  1  one-cycle pulse when rdata updates.
- cs_n, rd_n, wr_n  out  1 each  chip select, read strobe and write strobe (all active-low).
- a_d  out  1  0 = address cycle, 1 = data cycle.
- dout  out  DATA_W  value driven to the pins.
- din  in  DATA_W  value read from the pins.
- bus_oe  out  1  1 = FPGA drives the pins.

## Operation
- States: IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, RECOVER, DONE.
- One phase-cycle counter is reloaded on every state entry.
- A state exits when its counter reaches its parameter minus 1.
- IDLE + start:
  - capture op, addr, and max(burst_len, 1) into a word counter.
  - go to A_SETUP.
- Address cycle (A_*):
  - a_d=0, cs_n=0, dout=current address, bus_oe=1.
  - wr_n=0 only in A_PULSE; rd_n=1.
- Data cycle (D_*):
  - a_d=1, cs_n=0.
  - Write: on entry to D_SETUP, register wdata into dout and pulse wdata_ack. bus_oe=1, and wr_n=0 only in D_PULSE.
  - Read: bus_oe=0, and rd_n=0 only in D_PULSE. On the last D_PULSE cycle, register din into rdata. rdata_valid pulses on the following cycle.
- RECOVER:
  - cs_n=1, bus_oe=0, and both strobes high.
  - Decrement the word counter and increment the address modulo 2^DATA_W (0xFF wraps to 0x00).
  - At the end of RECOVER, go to A_SETUP if words remain and no abort is latched. Otherwise go to DONE.
- abort:
  - Latched whenever busy=1.
  - The current word always completes all of its phases.
  - Ignored in IDLE.
- DONE: lasts one cycle, with done=1 and busy=0, then returns to IDLE.
- start is ignored while busy or in DONE. Captured op and addr never change mid-transaction.

## Timing
- Reset values (applied asynchronously):
  - state=IDLE.
  - cs_n=rd_n=wr_n=1, a_d=0, bus_oe=0.
  - dout=0, rdata=0, and busy, done, rdata_valid, wdata_ack all 0.
  - Address, word counter and abort latch cleared.
- Reset asserted mid-operation deasserts all strobes immediately. No done pulse is produced.
- busy rises on the clock edge that samples start.
- Word length W = 2·(T_SETUP+T_PULSE+T_HOLD)+T_RECOVER, which is 19 cycles with the defaults.
- busy stays high for exactly N·W cycles, then done pulses for one cycle.
- wdata_ack is asserted on the first cycle of D_SETUP. The requester must present the next word's wdata before the next D_SETUP entry.
- A strobe never overlaps an a_d change. a_d and dout change only on SETUP entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single write (defaults, addr=0x21, wdata=0x5A):
  - wr_n low for 4 cycles with a_d=0 and dout=0x21.
  - Then wr_n low for 4 cycles with a_d=1 and dout=0x5A.
  - busy high for 19 cycles, then done for 1 cycle.
- Single read (addr=0x22, din=0xC3 during D_PULSE):
  - rd_n low for 4 cycles with bus_oe=0.
  - rdata=0xC3, with rdata_valid pulsed exactly once.
  - wr_n high throughout the data cycle.
- Burst write, burst_len=3, addr=0xFE:
  - Address cycles drive 0xFE, 0xFF, 0x00.
  - Three wdata_ack pulses; busy high for 57 cycles.
- burst_len=0: behaves exactly as burst_len=1. Also, start pulsed during busy is ignored: no second transaction, done pulses once.
- abort during word 1 of a burst_len=4 read: word 1 completes, done follows RECOVER, and only 1 rdata_valid is seen.
- reset_n low during D_PULSE of a write: wr_n, cs_n and busy go to 1/1/0 without waiting for a clock edge. No done pulse. After release, the next start runs normally.
